// File: rtl/imem_loader_if.sv
// Byte-stream handshake between the boot/test host and imem_loader.
// master: host side (drives valid/data); slave: loader side (drives ready).
interface imem_loader_if;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory writer.
// Receives a byte stream (2-byte little-endian word count, then payload),
// assembles little-endian 32-bit words and writes them through wen/waddr/wdata
// while holding the core in reset until the image is complete.
// Optional build macro IMEM_LOADER_CSUM_EN adds a trailing XOR checksum byte.
module imem_loader #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    imem_loader_if.slave      stream,
    output logic              wen,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              core_rst_n,
    output logic              done,
    output logic              err,
    output logic [LEN_W-1:0]  words_loaded
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LEN_LO = 3'd1;
    localparam logic [2:0] ST_LEN_HI = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_WRITE  = 3'd4;
`ifdef IMEM_LOADER_CSUM_EN
    localparam logic [2:0] ST_CSUM   = 3'd5;
`endif
    localparam logic [2:0] ST_DONE   = 3'd6;
    localparam logic [2:0] ST_ERR    = 3'd7;

    // State entered once the payload is complete (or empty).
`ifdef IMEM_LOADER_CSUM_EN
    localparam logic [2:0] ST_FINAL  = ST_CSUM;
`else
    localparam logic [2:0] ST_FINAL  = ST_DONE;
`endif

    // Largest legal word count: the full word-address space.
    localparam logic [LEN_W:0] MAX_WORDS = (LEN_W+1)'(1) << ADDR_W;

    logic [2:0]        state_q,        state_d;
    logic [LEN_W-1:0]  len_q,          len_d;
    logic [1:0]        byte_idx_q,     byte_idx_d;
    logic [ADDR_W-1:0] word_idx_q,     word_idx_d;
    logic [31:0]       asm_q,          asm_d;
    logic [ADDR_W-1:0] waddr_q,        waddr_d;
    logic [31:0]       wdata_q,        wdata_d;
    logic [LEN_W-1:0]  words_loaded_q, words_loaded_d;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]        xor_q,          xor_d;
`endif

    logic              accept;
    logic [LEN_W-1:0]  len_full;

    // Ready depends on state only, never on valid.
    assign stream.s_ready = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
`ifdef IMEM_LOADER_CSUM_EN
                            (state_q == ST_CSUM) ||
`endif
                            (state_q == ST_DATA);

    assign accept       = stream.s_valid && stream.s_ready;
    assign len_full     = LEN_W'({stream.s_data, len_q[7:0]});

    assign wen          = (state_q == ST_WRITE);
    assign waddr        = waddr_q;
    assign wdata        = wdata_q;
    assign done         = (state_q == ST_DONE);
    assign err          = (state_q == ST_ERR);
    assign core_rst_n   = (state_q == ST_DONE);
    assign words_loaded = words_loaded_q;

    // Next-state logic: header unpack, word assembly, write sequencing.
    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        byte_idx_d     = byte_idx_q;
        word_idx_d     = word_idx_q;
        asm_d          = asm_q;
        waddr_d        = waddr_q;
        wdata_d        = wdata_q;
        words_loaded_d = words_loaded_q;
`ifdef IMEM_LOADER_CSUM_EN
        xor_d          = xor_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d        = ST_LEN_LO;
                    words_loaded_d = '0;
                    word_idx_d     = '0;
                    byte_idx_d     = '0;
`ifdef IMEM_LOADER_CSUM_EN
                    xor_d          = '0;
`endif
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    len_d   = LEN_W'(stream.s_data);
                    state_d = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    len_d = len_full;
                    if (len_full == '0)
                        state_d = ST_FINAL;
                    else if ({1'b0, len_full} > MAX_WORDS)
                        state_d = ST_ERR;
                    else
                        state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    // Shift right so the first byte ends up in [7:0].
                    asm_d = {stream.s_data, asm_q[31:8]};
`ifdef IMEM_LOADER_CSUM_EN
                    xor_d = xor_q ^ stream.s_data;
`endif
                    if (byte_idx_q == 2'd3) begin
                        // Count advances on the edge that raises wen, so WRITE
                        // already sees the updated words_loaded for its compare.
                        byte_idx_d     = '0;
                        wdata_d        = {stream.s_data, asm_q[31:8]};
                        waddr_d        = word_idx_q;
                        word_idx_d     = word_idx_q + ADDR_W'(1);
                        words_loaded_d = words_loaded_q + LEN_W'(1);
                        state_d        = ST_WRITE;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end
            ST_WRITE: begin
                state_d = (words_loaded_q == len_q) ? ST_FINAL : ST_DATA;
            end
`ifdef IMEM_LOADER_CSUM_EN
            ST_CSUM: begin
                if (accept)
                    state_d = (stream.s_data == xor_q) ? ST_DONE : ST_ERR;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            len_q          <= '0;
            byte_idx_q     <= '0;
            word_idx_q     <= '0;
            asm_q          <= '0;
            waddr_q        <= '0;
            wdata_q        <= '0;
            words_loaded_q <= '0;
`ifdef IMEM_LOADER_CSUM_EN
            xor_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            byte_idx_q     <= byte_idx_d;
            word_idx_q     <= word_idx_d;
            asm_q          <= asm_d;
            waddr_q        <= waddr_d;
            wdata_q        <= wdata_d;
            words_loaded_q <= words_loaded_d;
`ifdef IMEM_LOADER_CSUM_EN
            xor_q          <= xor_d;
`endif
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes are queued when a word is
// driven and checked against each wen pulse. A second instance with
// ADDR_W=4 covers the length-limit boundary.
module tb_imem_loader;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start4 = 1'b0;

    logic        wen,  wen4;
    logic [15:0] waddr;
    logic [3:0]  waddr4;
    logic [31:0] wdata, wdata4;
    logic        core_rst_n, core_rst_n4;
    logic        done, done4;
    logic        err,  err4;
    logic [15:0] words_loaded, words_loaded4;

    int n_vec  = 0;
    int n_miss = 0;
    int wen_cnt  = 0;
    int wen4_cnt = 0;
    wr_t sb[$];
    logic [7:0] xsum;

    imem_loader_if bus();
    imem_loader_if bus4();

    imem_loader #(.ADDR_W(16), .LEN_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stream(bus),
        .wen(wen), .waddr(waddr), .wdata(wdata), .core_rst_n(core_rst_n),
        .done(done), .err(err), .words_loaded(words_loaded)
    );

    imem_loader #(.ADDR_W(4), .LEN_W(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .stream(bus4),
        .wen(wen4), .waddr(waddr4), .wdata(wdata4), .core_rst_n(core_rst_n4),
        .done(done4), .err(err4), .words_loaded(words_loaded4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every wen pulse of the main instance must match the queue head.
    always @(negedge clk) begin
        wr_t e;
        if (wen === 1'b1) begin
            wen_cnt++;
            if (sb.size() > 0) e = sb.pop_front();
            else begin e.addr = 32'hFFFF_FFFF; e.data = 32'hFFFF_FFFF; end
            chk("waddr", {16'h0, waddr}, e.addr);
            chk("wdata", wdata, e.data);
            chk("s_ready_in_write", {31'h0, bus.s_ready}, 32'h0);
        end
        if (wen4 === 1'b1) wen4_cnt++;
    end

    task automatic pulse_start(input int which);
        @(negedge clk);
        if (which == 4) start4 = 1'b1; else start = 1'b1;
        xsum = 8'h00;
        @(negedge clk);
        start = 1'b0;
        start4 = 1'b0;
    endtask

    // Present one byte; returns 1 time unit after the accepting edge.
    task automatic send_byte(input int which, input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        if (which == 4) begin
            bus4.s_valid = 1'b1; bus4.s_data = b;
            while (bus4.s_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        end else begin
            bus.s_valid = 1'b1; bus.s_data = b;
            while (bus.s_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        end
        if (n >= 50) chk("ready_timeout", n, 0);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        bus4.s_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] addr, input logic [31:0] w, input int gap);
        wr_t e;
        e.addr = addr; e.data = w;
        sb.push_back(e);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = w[8*i +: 8];
            xsum = xsum ^ b;
            if (gap != 0) repeat ($urandom_range(0, 3)) @(negedge clk);
            send_byte(0, b);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 30) begin @(negedge clk); n++; end
        chk("done", {31'h0, done}, 32'h1);
    endtask

    task automatic finish_load();
`ifdef IMEM_LOADER_CSUM_EN
        send_byte(0, xsum);
`endif
        wait_done();
    endtask

    initial begin
        logic [31:0] rw [4];
        bus.s_valid = 1'b0;  bus.s_data = 8'h00;
        bus4.s_valid = 1'b0; bus4.s_data = 8'h00;
        xsum = 8'h00;

        // Reset state
        #12;
        chk("rst_s_ready", {31'h0, bus.s_ready}, 32'h0);
        chk("rst_wen", {31'h0, wen}, 32'h0);
        chk("rst_waddr", {16'h0, waddr}, 32'h0);
        chk("rst_wdata", wdata, 32'h0);
        chk("rst_core_rst_n", {31'h0, core_rst_n}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_words", {16'h0, words_loaded}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Two-word image
        pulse_start(0);
        send_byte(0, 8'h02); send_byte(0, 8'h00);
        send_word(0, 32'h0000_0013, 0);
        send_word(1, 32'h0010_0093, 0);
        finish_load();
        chk("t1_words", {16'h0, words_loaded}, 32'd2);
        chk("t1_core_rst_n", {31'h0, core_rst_n}, 32'h1);
        chk("t1_wen_cnt", wen_cnt, 32'd2);

        // Empty image
        pulse_start(0);
        chk("start_clears_done", {31'h0, done}, 32'h0);
        chk("start_core_rst_n", {31'h0, core_rst_n}, 32'h0);
        send_byte(0, 8'h00); send_byte(0, 8'h00);
        finish_load();
        chk("t2_words", {16'h0, words_loaded}, 32'd0);
        chk("t2_wen_cnt", wen_cnt, 32'd2);
`ifdef IMEM_LOADER_CSUM_EN
        pulse_start(0);
        send_byte(0, 8'h00); send_byte(0, 8'h00); send_byte(0, 8'h01);
        @(negedge clk);
        chk("csum_bad_err", {31'h0, err}, 32'h1);
`endif

        // Length limit on the 4-bit address instance
        pulse_start(4);
        send_byte(4, 8'h11); send_byte(4, 8'h00);
        chk("t3_err", {31'h0, err4}, 32'h1);
        chk("t3_core_rst_n", {31'h0, core_rst_n4}, 32'h0);
        chk("t3_s_ready", {31'h0, bus4.s_ready}, 32'h0);
        repeat (3) @(negedge clk);
        chk("t3_wen_cnt", wen4_cnt, 32'd0);
        pulse_start(4);
        chk("t3_err_cleared", {31'h0, err4}, 32'h0);
        chk("t3_len_lo_ready", {31'h0, bus4.s_ready}, 32'h1);
        send_byte(4, 8'h10); send_byte(4, 8'h00);
        chk("t3_len16_ok_err", {31'h0, err4}, 32'h0);
        chk("t3_len16_in_data", {31'h0, bus4.s_ready}, 32'h1);

        // Random valid gaps
        pulse_start(0);
        send_byte(0, 8'h03); send_byte(0, 8'h00);
        for (int i = 0; i < 3; i++) send_word(i, $urandom, 1);
        finish_load();
        chk("t4_words", {16'h0, words_loaded}, 32'd3);
        chk("t4_wen_cnt", wen_cnt, 32'd5);

        // Asynchronous reset mid-load
        pulse_start(0);
        send_byte(0, 8'h04); send_byte(0, 8'h00);
        send_word(0, 32'hDEAD_BEEF, 0);
        send_byte(0, 8'h11); send_byte(0, 8'h22);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_s_ready", {31'h0, bus.s_ready}, 32'h0);
        chk("arst_wen", {31'h0, wen}, 32'h0);
        chk("arst_waddr", {16'h0, waddr}, 32'h0);
        chk("arst_wdata", wdata, 32'h0);
        chk("arst_core_rst_n", {31'h0, core_rst_n}, 32'h0);
        chk("arst_done", {31'h0, done}, 32'h0);
        chk("arst_words", {16'h0, words_loaded}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulse_start(0);
        send_byte(0, 8'h04); send_byte(0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            rw[i] = $urandom;
            send_word(i, rw[i], 0);
        end
        finish_load();
        chk("t5_words", {16'h0, words_loaded}, 32'd4);
        chk("t5_wen_cnt", wen_cnt, 32'd10);

        // start during DATA is ignored
        pulse_start(0);
        send_byte(0, 8'h02); send_byte(0, 8'h00);
        send_word(0, 32'h0123_4567, 0);
        begin
            wr_t e;
            e.addr = 1; e.data = 32'h89AB_CDEF;
            sb.push_back(e);
            send_byte(0, 8'hEF); send_byte(0, 8'hCD);
            xsum = xsum ^ 8'hEF ^ 8'hCD;
            pulse_start(0);
            xsum = 8'hEF ^ 8'hCD ^ 8'h67 ^ 8'h45 ^ 8'h23 ^ 8'h01;
            send_byte(0, 8'hAB); send_byte(0, 8'h89);
            xsum = xsum ^ 8'hAB ^ 8'h89;
        end
        finish_load();
        chk("t6_words", {16'h0, words_loaded}, 32'd2);
        chk("t6_wen_cnt", wen_cnt, 32'd12);
        chk("sb_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory that the fetch stage reads.
- Accepts a byte stream with a valid/ready handshake, unpacks a length header, and assembles little-endian 32-bit words.
- Drives the instruction-memory write port (wen/waddr/wdata) and holds the core in reset until the image is fully written.
- Sits between the test/boot host interface and the fetch stage's memory write inputs.

Parameters:
- ADDR_W, 16, word-address width; must match the fetch memory index pc[17:2].
- LEN_W, 16, width of the word-count header field (fixed to two bytes; LEN_W >= ADDR_W).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; asynchronous, active-low
- start  input  1  single-cycle pulse; begins a load when FSM is IDLE, DONE or ERR
- s_valid  input  1  byte stream valid
- s_data  input  8  byte stream data
- s_ready  output  1  byte stream ready
- wen  output  1  instruction memory write enable, one-cycle pulse per word
- waddr  output  ADDR_W  word address of current write
- wdata  output  32  assembled word
- core_rst_n  output  1  active-low reset to core/fetch; low until load completes
- done  output  1  high in DONE
- err  output  1  high in ERR
- words_loaded  output  LEN_W  count of words written in current load

Behaviour:
- Reset values: s_ready=0, wen=0, waddr=0, wdata=0, core_rst_n=0, done=0, err=0, words_loaded=0, FSM=IDLE, byte index=0, word index=0.
- A byte is accepted when s_valid && s_ready in the same cycle. s_ready is combinational from state only: 1 in LEN_LO, LEN_HI, DATA and CSUM; 0 elsewhere. s_ready never depends on s_valid.
- IDLE: waits for start; start -> LEN_LO. Clears words_loaded, word index, byte index and err.
- LEN_LO: accepts a byte into len[7:0] -> LEN_HI.
- LEN_HI: accepts a byte into len[15:8].
  - len == 0 -> DONE (or CSUM when the optional feature is compiled in).
  - len > 2**ADDR_W -> ERR.
  - Otherwise -> DATA.
- DATA: bytes fill wdata little-endian; the first byte goes to [7:0], the fourth to [31:24].
  - On acceptance of the 4th byte: the cycle after, wen=1 for exactly one cycle, with waddr = word index and wdata = the assembled word (both stable during that cycle).
  - words_loaded and word index increment in the same cycle as the wen pulse.
  - s_ready drops to 0 during the wen cycle (state WRITE), so there is one bubble per word.
  - After the write: if words_loaded == len -> DONE (or CSUM); else -> DATA.
- WRITE is an internal state between DATA and the next state; wen is asserted only in WRITE.
- DONE: core_rst_n=1, done=1; holds until start or rst_n.
- ERR: err=1, core_rst_n=0, s_ready=0; holds until start or rst_n.
- start handling:
  - Ignored in LEN_LO, LEN_HI, DATA, WRITE and CSUM.
  - In DONE or ERR, start -> LEN_LO. core_rst_n goes to 0 and done/err go to 0 the next cycle.
- Word address wraps never: the len check guarantees waddr <= 2**ADDR_W-1.
- Async rst_n assertion mid-load: all outputs return to reset values immediately. Words already written remain in memory and are not cleared.
- Throughput with continuous s_valid: 5 cycles per word (4 accept + 1 WRITE).

Optional Feature:
- IMEM_LOADER_CSUM_EN defined:
  - After the last word (or after LEN_HI when len==0), FSM enters CSUM and accepts one byte.
  - That byte is compared against the XOR of all payload bytes (header excluded).
  - Match -> DONE; mismatch -> ERR.
  - The running XOR is cleared on start.
- Not defined: CSUM state does not exist; the transitions go directly to DONE.

Test Plan:
- Reset, then start, then stream 02 00 | 13 00 00 00 | 93 00 10 00 -> wen pulses at waddr 0 with wdata 0x00000013 and at waddr 1 with wdata 0x00100093. Afterwards words_loaded=2, done=1, core_rst_n=1.
- start, then stream 00 00 -> DONE with no wen pulse and words_loaded=0. With CSUM_EN, a trailing byte 00 is required; trailing 00 -> DONE, trailing 01 -> ERR.
- Set ADDR_W=4 and send len=17 (11 00) -> ERR, err=1, core_rst_n=0, s_ready=0, no wen. A subsequent start -> LEN_LO, err=0.
- Randomly deassert s_valid in DATA with len=3 -> identical memory contents and 3 wen pulses. s_ready=0 exactly in each WRITE cycle.
- Assert rst_n low after 6 payload bytes of len=4 -> all outputs return to reset values asynchronously. After reset and start, a full reload writes addrs 0..3 correctly.
- Pulse start during DATA -> ignored; the load completes normally with the original len.
